// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants, state encoding and request decode helpers for the vscale
// data-memory responder.
package vscale_dmem_responder_pkg;

  localparam int XPR_LEN        = 32;
  localparam int MEM_TYPE_WIDTH = 3;

  // Access width lives in funct3[1:0]; funct3[2] (unsigned-load flag) is irrelevant here.
  localparam int MEM_SIZE_LO = 0;
  localparam int MEM_SIZE_HI = 1;

  localparam logic [1:0] MEM_TYPE_B = 2'd0;
  localparam logic [1:0] MEM_TYPE_H = 2'd1;
  localparam logic [1:0] MEM_TYPE_W = 2'd2;
  localparam logic [1:0] MEM_TYPE_D = 2'd3;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DMEM_RESP_STATE_WIDTH = 2;

  typedef enum logic [DMEM_RESP_STATE_WIDTH-1:0] {
    DMEM_RESP_IDLE = 2'd0,
    DMEM_RESP_BUSY = 2'd1,
    DMEM_RESP_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [XPR_LEN-3:0]   word;
    logic                 wen;
    logic [NUM_LANES-1:0] be;
    logic                 err;
  } dmem_req_t;

  function automatic logic [NUM_LANES-1:0] byte_en(input logic [1:0] size,
                                                   input logic [1:0] lo);
    logic [NUM_LANES-1:0] be;
    case (size)
      MEM_TYPE_B: be = 4'b0001 << lo;
      MEM_TYPE_H: be = 4'b0011 << {lo[1], 1'b0};
      MEM_TYPE_W: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/vscale_dmem_if.sv
// dmem port between the vscale core (master) and the responder (slave).
interface vscale_dmem_if;
  import vscale_dmem_responder_pkg::*;

  logic                      dmem_en;
  logic                      dmem_wen;
  logic [MEM_TYPE_WIDTH-1:0] dmem_size;
  logic [XPR_LEN-1:0]        dmem_addr;
  logic [XPR_LEN-1:0]        dmem_wdata_delayed;
  logic [XPR_LEN-1:0]        dmem_rdata;
  logic                      dmem_wait;
  logic                      dmem_badmem_e;

  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_rdata, dmem_wait, dmem_badmem_e
  );

  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_rdata, dmem_wait, dmem_badmem_e
  );
endinterface

// File: rtl/vscale_byte_ram.sv
// Word-organised RAM split into byte lanes: one byte-masked write port and one
// asynchronous read port. Contents are deliberately not reset.
module vscale_byte_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int NUM_LANES   = 4,
  parameter int LANE_W      = 8,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                             clk,
  input  logic [NUM_LANES-1:0]             we,
  input  logic [AW-1:0]                    waddr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
  input  logic [AW-1:0]                    raddr,
  output logic [NUM_LANES-1:0][LANE_W-1:0] rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we[l]) mem[waddr] <= wdata[l];
    end

    assign rdata[l] = mem[raddr];
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// dmem target: latches the address phase, optionally stalls WAIT_CYCLES, then
// completes the data phase against the owned RAM or raises badmem.
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  vscale_dmem_if.slave  dmem
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XPR_LEN:0] ADDR_LIMIT = (XPR_LEN+1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  dmem_req_t   req, req_nxt;

  logic [1:0]           size_code;
  logic                 err_new;
  logic [NUM_LANES-1:0] be_new;
  logic                 accept;
  logic                 in_resp;
  logic [NUM_LANES-1:0] ram_we;
  logic [XPR_LEN-1:0]   ram_rdata;
  logic                 unused_ok;

  assign size_code = dmem.dmem_size[MEM_SIZE_HI:MEM_SIZE_LO];
  assign be_new    = byte_en(size_code, dmem.dmem_addr[1:0]);
  assign err_new   = (size_code == MEM_TYPE_D)
                   | ((size_code == MEM_TYPE_H) & dmem.dmem_addr[0])
                   | ((size_code == MEM_TYPE_W) & (dmem.dmem_addr[1:0] != 2'b00))
                   | ({1'b0, dmem.dmem_addr} >= ADDR_LIMIT);

  assign dmem.dmem_wait = (state == DMEM_RESP_BUSY);
  assign accept         = dmem.dmem_en & ~dmem.dmem_wait;
  assign in_resp        = (state == DMEM_RESP_RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DMEM_RESP_IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      req   <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = req;
    case (state)
      DMEM_RESP_IDLE: ;
      DMEM_RESP_BUSY: if (cnt == 4'd0) state_nxt = DMEM_RESP_RESP;
                      else             cnt_nxt   = cnt - 4'd1;
      DMEM_RESP_RESP: state_nxt = DMEM_RESP_IDLE;
      default:        state_nxt = DMEM_RESP_IDLE;
    endcase
    // A new address phase may overlap the completing data phase.
    if (accept) begin
      req_nxt.word = dmem.dmem_addr[XPR_LEN-1:2];
      req_nxt.wen  = dmem.dmem_wen;
      req_nxt.be   = be_new;
      req_nxt.err  = err_new;
      if (WAIT_CYCLES == 0) begin
        state_nxt = DMEM_RESP_RESP;
      end else begin
        state_nxt = DMEM_RESP_BUSY;
        cnt_nxt   = CNT_LOAD;
      end
    end
  end

  assign ram_we = {NUM_LANES{in_resp & req.wen & ~req.err}} & req.be;

  vscale_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .NUM_LANES   (NUM_LANES),
    .LANE_W      (LANE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (req.word[AW-1:0]),
    .wdata (dmem.dmem_wdata_delayed),
    .raddr (req.word[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign dmem.dmem_rdata    = (in_resp & ~req.wen & ~req.err) ? ram_rdata : '0;
  assign dmem.dmem_badmem_e = in_resp & req.err;

  // Upper word bits only feed the range check; funct3[2] never matters here.
  assign unused_ok = ^{dmem.dmem_size[2], req.word};

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed bench for the dmem responder: a zero-wait and a three-wait instance
// are compared every cycle against a timing/memory model built from access rules.
module tb_vscale_dmem_responder;
  import vscale_dmem_responder_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vscale_dmem_if i0();
  vscale_dmem_if i1();

  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .dmem(i0));
  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset_n(reset_n), .dmem(i1));

  int checks = 0;
  int failures = 0;

  // Model: each access has an absolute response cycle = accept cycle + 1 + wait.
  int unsigned cyc = 0;
  bit          pend [2];
  int unsigned rcyc [2];
  bit          p_wen [2];
  bit          p_err [2];
  logic [31:0] p_addr [2];
  logic [2:0]  p_size [2];
  bit [31:0]   mm [int unsigned];

  function automatic int wc(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit m_wait(int k);
    return pend[k] && (cyc < rcyc[k]);
  endfunction

  function automatic bit m_resp(int k);
    return pend[k] && (cyc == rcyc[k]);
  endfunction

  function automatic bit m_err(logic [2:0] s, logic [31:0] a);
    return (s[1:0] == 2'd3) || (s[1:0] == 2'd1 && a[0]) ||
           (s[1:0] == 2'd2 && a[1:0] != 2'd0) || (64'(a) >= 64'(DEPTH * 4));
  endfunction

  function automatic int unsigned key_of(int k, logic [31:0] a);
    return int'(k) * 65536 + int'(a[31:2]);
  endfunction

  task automatic get_in(input int k, output bit en, output bit wen,
                        output logic [2:0] s, output logic [31:0] a, output logic [31:0] wd);
    if (k == 0) begin
      en = i0.dmem_en; wen = i0.dmem_wen; s = i0.dmem_size; a = i0.dmem_addr; wd = i0.dmem_wdata_delayed;
    end else begin
      en = i1.dmem_en; wen = i1.dmem_wen; s = i1.dmem_size; a = i1.dmem_addr; wd = i1.dmem_wdata_delayed;
    end
  endtask

  task automatic get_out(input int k, output logic [31:0] rd, output logic w, output logic b);
    if (k == 0) begin rd = i0.dmem_rdata; w = i0.dmem_wait; b = i0.dmem_badmem_e; end
    else        begin rd = i1.dmem_rdata; w = i1.dmem_wait; b = i1.dmem_badmem_e; end
  endtask

  task automatic commit(int k, logic [31:0] wd);
    int unsigned key;
    bit [31:0] w;
    int sh;
    key = key_of(k, p_addr[k]);
    if (p_size[k][1:0] == 2'd2) begin
      mm[key] = wd;
    end else if (mm.exists(key)) begin
      w = mm[key];
      if (p_size[k][1:0] == 2'd1) begin
        sh = p_addr[k][1] ? 16 : 0;
        w[sh +: 16] = wd[sh +: 16];
      end else begin
        sh = 8 * int'(p_addr[k][1:0]);
        w[sh +: 8] = wd[sh +: 8];
      end
      mm[key] = w;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit w, r, en, wen;
        logic [2:0] s;
        logic [31:0] a, wd;
        w = m_wait(k);
        r = m_resp(k);
        get_in(k, en, wen, s, a, wd);
        if (r) begin
          if (p_wen[k] && !p_err[k]) commit(k, wd);
          pend[k] = 1'b0;
        end
        if (en && !w) begin
          pend[k]   = 1'b1;
          rcyc[k]   = cyc + 1 + wc(k);
          p_wen[k]  = wen;
          p_size[k] = s;
          p_addr[k] = a;
          p_err[k]  = m_err(s, a);
        end
      end
      cyc++;
    end
  end

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[u%0d] got=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit r, known;
      logic [31:0] er, ar;
      logic aw, ab;
      r = m_resp(k);
      er = '0;
      known = 1'b1;
      if (r && !p_err[k] && !p_wen[k]) begin
        if (mm.exists(key_of(k, p_addr[k]))) er = mm[key_of(k, p_addr[k])];
        else known = 1'b0;
      end
      get_out(k, ar, aw, ab);
      chk("wait", k, 32'(aw), 32'(m_wait(k)));
      chk("badmem", k, 32'(ab), 32'(r && p_err[k]));
      if (known) chk("rdata", k, ar, er);
    end
  end

  task automatic set_in(int k, bit en, bit wen, logic [2:0] s, logic [31:0] a);
    if (k == 0) begin i0.dmem_en = en; i0.dmem_wen = wen; i0.dmem_size = s; i0.dmem_addr = a; end
    else        begin i1.dmem_en = en; i1.dmem_wen = wen; i1.dmem_size = s; i1.dmem_addr = a; end
  endtask

  task automatic set_wd(int k, logic [31:0] wd);
    if (k == 0) i0.dmem_wdata_delayed = wd;
    else        i1.dmem_wdata_delayed = wd;
  endtask

  task automatic idle(int k);
    set_in(k, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  // Holds the request until the model says it is taken; data follows one cycle later.
  task automatic issue(int k, bit wen, logic [2:0] s, logic [31:0] a, logic [31:0] wd);
    int n;
    n = 0;
    set_in(k, 1'b1, wen, s, a);
    while (m_wait(k) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("issue_timeout", k, 32'd1, 32'd0);
    @(posedge clk); #1;
    set_wd(k, wd);
  endtask

  task automatic to_resp(int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_resp(k) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("resp_timeout", k, 32'd1, 32'd0);
    #1;
  endtask

  initial begin
    int nw;
    idle(0); idle(1); set_wd(0, '0); set_wd(1, '0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_wait", 1, 32'(i1.dmem_wait), 32'd0);
    chk("rst_badmem", 1, 32'(i1.dmem_badmem_e), 32'd0);
    chk("rst_rdata", 0, i0.dmem_rdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance
    issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0);
    idle(0); to_resp(0);
    chk("lw_after_sw", 0, i0.dmem_rdata, 32'hDEADBEEF);

    issue(0, 1'b1, 3'b010, 32'h10, 32'h11223344);
    issue(0, 1'b1, 3'b000, 32'h13, 32'hAAAAAAAA);
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0);
    idle(0); to_resp(0);
    chk("sb_merge", 0, i0.dmem_rdata, 32'hAA223344);

    issue(0, 1'b0, 3'b101, 32'h12, 32'h0);
    idle(0); to_resp(0);
    chk("lhu_rdata", 0, i0.dmem_rdata, 32'hAA223344);
    chk("lhu_badmem", 0, 32'(i0.dmem_badmem_e), 32'd0);

    issue(0, 1'b1, 3'b010, 32'h20, 32'h55667788);
    issue(0, 1'b1, 3'b001, 32'h21, 32'hBBBBBBBB);
    idle(0); to_resp(0);
    chk("sh_misalign_badmem", 0, 32'(i0.dmem_badmem_e), 32'd1);
    chk("sh_misalign_rdata", 0, i0.dmem_rdata, 32'd0);
    issue(0, 1'b0, 3'b010, 32'h20, 32'h0);
    idle(0); to_resp(0);
    chk("lw_after_bad_sh", 0, i0.dmem_rdata, 32'h55667788);

    issue(0, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0);
    idle(0); to_resp(0);
    chk("oor_badmem", 0, 32'(i0.dmem_badmem_e), 32'd1);
    chk("oor_rdata", 0, i0.dmem_rdata, 32'd0);

    issue(0, 1'b1, 3'b010, 32'h8, 32'h01020304);
    issue(0, 1'b1, 3'b011, 32'h8, 32'hFFFFFFFF);
    idle(0); to_resp(0);
    chk("sd_badmem", 0, 32'(i0.dmem_badmem_e), 32'd1);
    issue(0, 1'b0, 3'b010, 32'h8, 32'h0);
    idle(0); to_resp(0);
    chk("sd_no_write", 0, i0.dmem_rdata, 32'h01020304);

    // Three-wait instance
    issue(1, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D);
    issue(1, 1'b0, 3'b010, 32'h0, 32'h0);
    idle(1);
    nw = 0;
    @(negedge clk);
    while (i1.dmem_wait === 1'b1 && nw < 20) begin nw++; @(negedge clk); end
    chk("wait_cycles", 1, 32'(nw), 32'd3);
    chk("lw_w3", 1, i1.dmem_rdata, 32'hCAFEF00D);
    #1;
    issue(1, 1'b1, 3'b010, 32'h4, 32'h12345678);
    idle(1);
    @(negedge clk); #1;
    chk("accept_in_resp", 1, 32'(i1.dmem_wait), 32'd1);
    issue(1, 1'b0, 3'b010, 32'h4, 32'h0);
    idle(1); to_resp(1);
    chk("lw_w3_b", 1, i1.dmem_rdata, 32'h12345678);

    // Reset while a store is stalled
    issue(1, 1'b1, 3'b010, 32'h40, 32'h77777777);
    issue(1, 1'b1, 3'b010, 32'h40, 32'h99999999);
    idle(1);
    @(negedge clk); #1;
    chk("busy_before_rst", 1, 32'(i1.dmem_wait), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_wait", 1, 32'(i1.dmem_wait), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b0, 3'b010, 32'h40, 32'h0);
    idle(1); to_resp(1);
    chk("no_write_after_rst", 1, i1.dmem_rdata, 32'h77777777);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
